// File: rtl/cray_mult_pkg.sv
// rtl/cray_mult_pkg.sv - shared helpers for the pipelined address multiplier
package cray_mult_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mult_mode_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Product is passed zero-extended to MAX_W*2; only bits [2w-1:0] are meaningful.
    function automatic logic ovf_check(input logic [2*MAX_W-1:0] prod, input int w,
                                       input mult_mode_e mode);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 2*MAX_W; i++) begin
            if (mode == MODE_SIGNED) begin
                if (i >= w - 1 && i < 2*w && prod[i] != prod[2*w-1])
                    r = 1'b1;
            end else begin
                if (i >= w && i < 2*w && prod[i])
                    r = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addr_mult_stage.sv
// rtl/addr_mult_stage.sv - one registered PP_PER_STAGE-bit accumulate step
module addr_mult_stage
    import cray_mult_pkg::*;
#(
    parameter int WIDTH        = 24,
    parameter int PP_PER_STAGE = 4,
    parameter int TAG_W        = 3,
    parameter int STAGE_IDX    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic                 i_signed,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [2*WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    input  logic [2*WIDTH-1:0]   i_acc,
    output logic                 o_valid,
    output logic                 o_signed,
    output logic [TAG_W-1:0]     o_tag,
    output logic [2*WIDTH-1:0]   o_mcand,
    output logic [WIDTH-1:0]     o_mplier,
    output logic [2*WIDTH-1:0]   o_acc
);

    localparam int LO = (STAGE_IDX - 1) * PP_PER_STAGE;

    typedef struct packed {
        logic                valid;
        mult_mode_e          mode;
        logic [TAG_W-1:0]    tag;
        logic [2*WIDTH-1:0]  mcand;
        logic [WIDTH-1:0]    mplier;
        logic [2*WIDTH-1:0]  acc;
    } stage_t;

    stage_t r_stage;

    // Padding lets a short final stage index past WIDTH; those bits read as zero.
    logic [WIDTH+PP_PER_STAGE-1:0] w_mp_pad;
    logic [2*WIDTH-1:0]            w_sum;

    assign w_mp_pad = {{PP_PER_STAGE{1'b0}}, i_mplier};

    always_comb begin
        w_sum = i_acc;
        for (int j = 0; j < PP_PER_STAGE; j++) begin
            if (w_mp_pad[LO+j]) begin
                // Signed multiplier MSB carries weight -2^(W-1).
                if (i_signed && (LO + j == WIDTH - 1))
                    w_sum = w_sum - (i_mcand << (LO + j));
                else
                    w_sum = w_sum + (i_mcand << (LO + j));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage.valid <= i_valid & ~i_flush;
            if (i_valid) begin
                r_stage.mode   <= i_signed ? MODE_SIGNED : MODE_UNSIGNED;
                r_stage.tag    <= i_tag;
                r_stage.mcand  <= i_mcand;
                r_stage.mplier <= i_mplier;
                r_stage.acc    <= w_sum;
            end
        end
    end

    assign o_valid  = r_stage.valid;
    assign o_signed = (r_stage.mode == MODE_SIGNED);
    assign o_tag    = r_stage.tag;
    assign o_mcand  = r_stage.mcand;
    assign o_mplier = r_stage.mplier;
    assign o_acc    = r_stage.acc;

endmodule

// File: rtl/addr_mult_pipe.sv
// rtl/addr_mult_pipe.sv - fully pipelined A-register multiply unit with tag tracking and flush
module addr_mult_pipe
    import cray_mult_pkg::*;
#(
    parameter int WIDTH        = 24,
    parameter int PP_PER_STAGE = 4,
    parameter int TAG_W        = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_aj,
    input  logic [WIDTH-1:0]   i_ak,
    input  logic               i_signed,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic               i_flush,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_overflow,
    output logic [TAG_W-1:0]   o_tag,
    output logic               o_busy
);

    localparam int NSTAGE = ceil_div(WIDTH, PP_PER_STAGE);

    logic               w_valid  [0:NSTAGE];
    logic               w_signed [0:NSTAGE];
    logic [TAG_W-1:0]   w_tag    [0:NSTAGE];
    logic [2*WIDTH-1:0] w_mcand  [0:NSTAGE];
    logic [WIDTH-1:0]   w_mplier [0:NSTAGE];
    logic [2*WIDTH-1:0] w_acc    [0:NSTAGE];
    logic               w_busy;
    logic               w_ovf;

    logic               r_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_overflow;
    logic [TAG_W-1:0]   r_tag;

    assign w_valid[0]  = i_valid;
    assign w_signed[0] = i_signed;
    assign w_tag[0]    = i_tag;
    assign w_mcand[0]  = i_signed ? {{WIDTH{i_aj[WIDTH-1]}}, i_aj} : {{WIDTH{1'b0}}, i_aj};
    assign w_mplier[0] = i_ak;
    assign w_acc[0]    = '0;

    generate
        for (genvar s = 1; s <= NSTAGE; s++) begin : g_stage
            addr_mult_stage #(
                .WIDTH        (WIDTH),
                .PP_PER_STAGE (PP_PER_STAGE),
                .TAG_W        (TAG_W),
                .STAGE_IDX    (s)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_flush  (i_flush),
                .i_valid  (w_valid[s-1]),
                .i_signed (w_signed[s-1]),
                .i_tag    (w_tag[s-1]),
                .i_mcand  (w_mcand[s-1]),
                .i_mplier (w_mplier[s-1]),
                .i_acc    (w_acc[s-1]),
                .o_valid  (w_valid[s]),
                .o_signed (w_signed[s]),
                .o_tag    (w_tag[s]),
                .o_mcand  (w_mcand[s]),
                .o_mplier (w_mplier[s]),
                .o_acc    (w_acc[s])
            );
        end
    endgenerate

    always_comb begin
        w_busy = 1'b0;
        for (int s = 1; s <= NSTAGE; s++)
            w_busy = w_busy | w_valid[s];
    end

    assign w_ovf = ovf_check({{(2*MAX_W-2*WIDTH){1'b0}}, w_acc[NSTAGE]}, WIDTH,
                             w_signed[NSTAGE] ? MODE_SIGNED : MODE_UNSIGNED);

    // Result fields only move when a live op lands, so they hold across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_valid <= w_valid[NSTAGE] & ~i_flush;
            if (w_valid[NSTAGE] && !i_flush) begin
                r_result   <= w_acc[NSTAGE][WIDTH-1:0];
                r_overflow <= w_ovf;
                r_tag      <= w_tag[NSTAGE];
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_result   = r_result;
    assign o_overflow = r_overflow;
    assign o_tag      = r_tag;
    assign o_busy     = w_busy;

endmodule

// File: tb/tb_addr_mult_pipe.sv
// tb/tb_addr_mult_pipe.sv - directed-vector and reference-model bench for addr_mult_pipe
module tb_addr_mult_pipe;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_signed, a_flush;
    logic [23:0] a_aj, a_ak;
    logic [2:0]  a_tag;
    logic        a_o_valid, a_o_ovf, a_o_busy;
    logic [23:0] a_o_result;
    logic [2:0]  a_o_tag;

    logic        b_valid, b_signed, b_flush;
    logic [31:0] b_aj, b_ak;
    logic [2:0]  b_tag;
    logic        b_o_valid, b_o_ovf, b_o_busy;
    logic [31:0] b_o_result;
    logic [2:0]  b_o_tag;

    int n_checks;
    int n_fail;

    addr_mult_pipe #(.WIDTH(24), .PP_PER_STAGE(4), .TAG_W(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_aj(a_aj), .i_ak(a_ak),
        .i_signed(a_signed), .i_tag(a_tag), .i_flush(a_flush), .o_valid(a_o_valid),
        .o_result(a_o_result), .o_overflow(a_o_ovf), .o_tag(a_o_tag), .o_busy(a_o_busy)
    );

    addr_mult_pipe #(.WIDTH(32), .PP_PER_STAGE(5), .TAG_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_aj(b_aj), .i_ak(b_ak),
        .i_signed(b_signed), .i_tag(b_tag), .i_flush(b_flush), .o_valid(b_o_valid),
        .o_result(b_o_result), .o_overflow(b_o_ovf), .o_tag(b_o_tag), .o_busy(b_o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] aj;
        logic [23:0] ak;
        logic        sg;
        logic [2:0]  tag;
        logic [23:0] res;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic [2:0]  tag;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic [23:0] aj, input logic [23:0] ak, input logic sg,
                           input logic [2:0] tag);
        a_valid = 1'b1; a_aj = aj; a_ak = ak; a_signed = sg; a_tag = tag;
        tick();
        a_valid = 1'b0; a_aj = '0; a_ak = '0; a_signed = 1'b0; a_tag = '0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        a_valid = 0; a_signed = 0; a_flush = 0; a_aj = 0; a_ak = 0; a_tag = 0;
        b_valid = 0; b_signed = 0; b_flush = 0; b_aj = 0; b_ak = 0; b_tag = 0;

        vecs[0] = '{24'h000003, 24'h000005, 1'b0, 3'd2, 24'h00000F, 1'b0};
        vecs[1] = '{24'h001000, 24'h001000, 1'b0, 3'd1, 24'h000000, 1'b1};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 3'd3, 24'h000001, 1'b0};
        vecs[3] = '{24'h800000, 24'hFFFFFF, 1'b1, 3'd4, 24'h800000, 1'b1};
        vecs[4] = '{24'h400000, 24'h000002, 1'b1, 3'd5, 24'h800000, 1'b1};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'd6, 24'h000001, 1'b1};
        vecs[6] = '{24'hFFFFFF, 24'h000002, 1'b1, 3'd7, 24'hFFFFFE, 1'b0};
        vecs[7] = '{24'h000000, 24'h123456, 1'b0, 3'd0, 24'h000000, 1'b0};
        vecs[8] = '{24'h000FFF, 24'h001001, 1'b0, 3'd1, 24'hFFFFFF, 1'b0};

        repeat (3) tick();
        check("reset_valid",  {63'd0, a_o_valid}, 64'd0);
        check("reset_result", {40'd0, a_o_result}, 64'd0);
        check("reset_ovf",    {63'd0, a_o_ovf}, 64'd0);
        check("reset_tag",    {61'd0, a_o_tag}, 64'd0);
        check("reset_busy",   {63'd0, a_o_busy}, 64'd0);
        check("reset_b_valid", {63'd0, b_o_valid}, 64'd0);
        rst_n = 1'b1;

        // Single ops: latency, product, overflow, tag.
        for (int v = 0; v < 9; v++) begin
            int lat;
            issue_a(vecs[v].aj, vecs[v].ak, vecs[v].sg, vecs[v].tag);
            lat = 0;
            while (!a_o_valid && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'd6);
            check($sformatf("vec%0d_result", v), {40'd0, a_o_result}, {40'd0, vecs[v].res});
            check($sformatf("vec%0d_ovf", v), {63'd0, a_o_ovf}, {63'd0, vecs[v].ovf});
            check($sformatf("vec%0d_tag", v), {61'd0, a_o_tag}, {61'd0, vecs[v].tag});
            tick();
            check($sformatf("vec%0d_pulse", v), {63'd0, a_o_valid}, 64'd0);
            check($sformatf("vec%0d_hold", v), {40'd0, a_o_result}, {40'd0, vecs[v].res});
        end

        // Six back-to-back ops fill the pipe; results emerge in order.
        for (int i = 0; i < 6; i++)
            issue_a(24'(i + 1), 24'h000010, 1'b0, 3'(i));
        check("b2b_busy", {63'd0, a_o_busy}, 64'd1);
        check("b2b_not_yet", {63'd0, a_o_valid}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("b2b%0d_valid", i), {63'd0, a_o_valid}, 64'd1);
            check($sformatf("b2b%0d_tag", i), {61'd0, a_o_tag}, 64'(i));
            check($sformatf("b2b%0d_result", i), {40'd0, a_o_result}, 64'((i + 1) * 16));
        end
        tick();
        check("b2b_end_valid", {63'd0, a_o_valid}, 64'd0);
        check("b2b_end_busy", {63'd0, a_o_busy}, 64'd0);

        // Flush at edge 3 with a simultaneous issue: nothing must come out.
        issue_a(24'h000007, 24'h000003, 1'b0, 3'd1);
        issue_a(24'h000009, 24'h000003, 1'b0, 3'd2);
        issue_a(24'h00000B, 24'h000003, 1'b0, 3'd3);
        a_flush = 1'b1;
        issue_a(24'h00000D, 24'h000003, 1'b0, 3'd4);
        a_flush = 1'b0;
        check("flush_busy", {63'd0, a_o_busy}, 64'd0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 12; c++) begin
                if (a_o_valid) seen++;
                tick();
            end
            check("flush_no_valid", 64'(seen), 64'd0);
        end
        begin
            int lat;
            issue_a(24'h000100, 24'h000011, 1'b0, 3'd5);
            lat = 0;
            while (!a_o_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("post_flush_latency", 64'(lat), 64'd6);
            check("post_flush_result", {40'd0, a_o_result}, 64'h1100);
            check("post_flush_tag", {61'd0, a_o_tag}, 64'd5);
        end

        // Async reset mid-flight clears outputs without waiting for a clock edge.
        issue_a(24'h800000, 24'hFFFFFF, 1'b1, 3'd7);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid",  {63'd0, a_o_valid}, 64'd0);
        check("midrst_result", {40'd0, a_o_result}, 64'd0);
        check("midrst_ovf",    {63'd0, a_o_ovf}, 64'd0);
        check("midrst_tag",    {61'd0, a_o_tag}, 64'd0);
        check("midrst_busy",   {63'd0, a_o_busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        begin
            int lat;
            issue_a(24'h000006, 24'h000007, 1'b0, 3'd3);
            lat = 0;
            while (!a_o_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("postrst_latency", 64'(lat), 64'd6);
            check("postrst_result", {40'd0, a_o_result}, 64'd42);
        end

        // W=32, PP=5: streamed random ops against a 64-bit arithmetic reference.
        begin
            int issued, got, cyc;
            issued = 0; got = 0; cyc = 0;
            while ((issued < 40 || sb.size() != 0) && cyc < 600) begin
                if (b_o_valid) begin
                    if (sb.size() == 0) begin
                        check("rand_unexpected_valid", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check($sformatf("rand%0d_result", got), {32'd0, b_o_result}, {32'd0, e.res});
                        check($sformatf("rand%0d_ovf", got), {63'd0, b_o_ovf}, {63'd0, e.ovf});
                        check($sformatf("rand%0d_tag", got), {61'd0, b_o_tag}, {61'd0, e.tag});
                        got++;
                    end
                end
                if (issued < 40 && $urandom_range(0, 3) != 0) begin
                    logic [63:0] p;
                    logic [31:0] a, b;
                    logic        sg;
                    exp_t        e;
                    case ($urandom_range(0, 5))
                        0: a = 32'h80000000;
                        1: a = 32'hFFFFFFFF;
                        2: a = 32'($urandom_range(0, 65535));
                        default: a = $urandom;
                    endcase
                    b  = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
                    sg = 1'($urandom_range(0, 1));
                    if (sg) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                    else    p = {32'd0, a} * {32'd0, b};
                    e.res = p[31:0];
                    e.ovf = sg ? !((p[63:31] == 33'd0) || (p[63:31] == {33{1'b1}})) : (p[63:32] != 32'd0);
                    e.tag = 3'($urandom_range(0, 7));
                    b_valid = 1'b1; b_aj = a; b_ak = b; b_signed = sg; b_tag = e.tag;
                    sb.push_back(e);
                    issued++;
                end else begin
                    b_valid = 1'b0;
                end
                tick();
                cyc++;
            end
            b_valid = 1'b0;
            check("rand_all_issued", 64'(issued), 64'd40);
            check("rand_all_drained", 64'(got), 64'd40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
